// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Runs up to three programs on a core, one per Start/Ack handshake.
//   Each handshake loads the start PC of the next program, lets the core run
//   until it halts or a cycle budget expires, then reports the result.
//
// Ports
//   CLK        : clock, all state updates on its rising edge
//   Reset      : synchronous, active-high reset
//   Start      : request to run the next program (4-phase with Ack)
//   Done       : core has executed its halt instruction
//   DivZero    : divide-by-zero seen by the exception checker
//   ProgState  : 00 idle, 01/10/11 = program 1/2/3 active
//   PCInit     : start PC to load into the core
//   LoadPC     : one-cycle strobe that loads PCInit into the PC
//   CoreEnable : core may fetch and execute
//   Ack        : program finished, results valid
//   ErrCode    : bit0 = divide-by-zero seen, bit1 = timeout
//   CycleCount : RUN cycles of the current or last program
//   dbg_state  : current FSM state (00 IDLE, 01 LOAD, 10 RUN, 11 ACK)
//
// Handshake: Start is raised to request a program; Ack rises once the
// program has finished and stays high until Start is dropped; the block
// returns to IDLE on the edge where it sees Start low while in ACK.
//
// Every output comes straight from a flop. The always_comb block computes
// the next value of every register; the always_ff blocks only load them.
// ---------------------------------------------------------------------------
module prog_sequencer #(
  parameter logic [9:0]  PROG1_START = 10'd0,
  parameter logic [9:0]  PROG2_START = 10'd96,
  parameter logic [9:0]  PROG3_START = 10'd224,
  parameter logic [15:0] TIMEOUT     = 16'd4000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Done,
  input  logic        DivZero,
  output logic [1:0]  ProgState,
  output logic [9:0]  PCInit,
  output logic        LoadPC,
  output logic        CoreEnable,
  output logic        Ack,
  output logic [1:0]  ErrCode,
  output logic [15:0] CycleCount,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  // Count value on which the last permitted RUN cycle executes.
  localparam logic [15:0] CNT_LAST = TIMEOUT - 16'd1;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state, state_nx;
  logic [1:0]  idx, idx_nx;          // next program to run, 1..3
  logic [1:0]  prog_nx;
  logic [9:0]  pc_nx;
  logic        load_nx;
  logic        en_nx;
  logic        ack_nx;
  logic [1:0]  err_nx;
  logic [15:0] cnt_nx;
  logic [9:0]  start_pc;

  always_comb begin
    case (idx)
      2'd2:    start_pc = PROG2_START;
      2'd3:    start_pc = PROG3_START;
      default: start_pc = PROG1_START;
    endcase
  end

  // Next-state and next-output logic. Defaults hold the data registers and
  // drop the strobes, so each state only states what changes.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    prog_nx  = ProgState;
    pc_nx    = PCInit;
    load_nx  = 1'b0;
    en_nx    = 1'b0;
    ack_nx   = 1'b0;
    err_nx   = ErrCode;
    cnt_nx   = CycleCount;

    case (state)
      S_IDLE: begin
        if (Start) begin
          state_nx = S_LOAD;
          prog_nx  = idx;
          pc_nx    = start_pc;
          load_nx  = 1'b1;
          err_nx   = 2'b00;
          cnt_nx   = 16'd0;
        end
      end

      S_LOAD: begin
        state_nx = S_RUN;
        en_nx    = 1'b1;
        err_nx   = 2'b00;
        cnt_nx   = 16'd0;
      end

      S_RUN: begin
        // A divide-by-zero is sticky and is recorded even on the edge that
        // leaves RUN.
        if (DivZero) begin
          err_nx[0] = 1'b1;
        end
        if (Done) begin
          // Halt beats timeout when both land on the same cycle.
          state_nx = S_ACK;
          ack_nx   = 1'b1;
        end else if (CycleCount == CNT_LAST) begin
          state_nx  = S_ACK;
          ack_nx    = 1'b1;
          err_nx[1] = 1'b1;
        end else begin
          en_nx = 1'b1;
          if (CycleCount != CNT_MAX) begin
            cnt_nx = CycleCount + 16'd1;
          end
        end
      end

      S_ACK: begin
        ack_nx = 1'b1;
        if (!Start) begin
          state_nx = S_IDLE;
          ack_nx   = 1'b0;
          prog_nx  = 2'd0;
          idx_nx   = (idx == 2'd3) ? 2'd1 : idx + 2'd1;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      idx        <= 2'd1;
      ProgState  <= 2'd0;
      PCInit     <= PROG1_START;
      LoadPC     <= 1'b0;
      CoreEnable <= 1'b0;
      Ack        <= 1'b0;
      ErrCode    <= 2'b00;
      CycleCount <= 16'd0;
    end else begin
      idx        <= idx_nx;
      ProgState  <= prog_nx;
      PCInit     <= pc_nx;
      LoadPC     <= load_nx;
      CoreEnable <= en_nx;
      Ack        <= ack_nx;
      ErrCode    <= err_nx;
      CycleCount <= cnt_nx;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_prog_sequencer.sv
// ---------------------------------------------------------------------------
// tb_prog_sequencer
//   Directed bench for prog_sequencer (TIMEOUT overridden to 16).
//   A cycle table drives inputs and lists the hand-computed outputs after
//   each step; a second phase runs four handshakes and checks the program
//   order against an expected queue.
// ---------------------------------------------------------------------------
module tb_prog_sequencer;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_ACK  = 2'd3;

  logic        clk;
  logic        reset;
  logic        start;
  logic        done;
  logic        div_zero;
  logic [1:0]  prog_state;
  logic [9:0]  pc_init;
  logic        load_pc;
  logic        core_enable;
  logic        ack;
  logic [1:0]  err_code;
  logic [15:0] cycle_count;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];   // {ProgState, PCInit} per LOAD, in order

  prog_sequencer #(
    .PROG1_START(10'd0),
    .PROG2_START(10'd96),
    .PROG3_START(10'd224),
    .TIMEOUT    (16'd16)
  ) dut (
    .CLK       (clk),
    .Reset     (reset),
    .Start     (start),
    .Done      (done),
    .DivZero   (div_zero),
    .ProgState (prog_state),
    .PCInit    (pc_init),
    .LoadPC    (load_pc),
    .CoreEnable(core_enable),
    .Ack       (ack),
    .ErrCode   (err_code),
    .CycleCount(cycle_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        st;
    logic        dn;
    logic        dz;
    int          reps;
    logic [1:0]  e_state;
    logic [1:0]  e_prog;
    logic [9:0]  e_pc;
    logic        e_load;
    logic        e_en;
    logic        e_ack;
    logic [1:0]  e_err;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(logic rst, logic st, logic dn, logic dz, int reps,
                              logic [1:0] es, logic [1:0] ep, logic [9:0] epc,
                              logic el, logic een, logic ea, logic [1:0] ee,
                              logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.st = st; v.dn = dn; v.dz = dz; v.reps = reps;
    v.e_state = es; v.e_prog = ep; v.e_pc = epc; v.e_load = el;
    v.e_en = een; v.e_ack = ea; v.e_err = ee; v.e_cnt = ec;
    return v;
  endfunction

  vec_t vecs[31];

  // One full handshake with a fixed number of Done-low RUN cycles.
  task automatic run_prog(input int run_cycles, input int n);
    logic [11:0] exp;
    int          k;
    start = 1'b1;
    k = 0;
    tick();
    while (!load_pc && k < 10) begin
      tick();
      k++;
    end
    if (!load_pc) begin
      checks++;
      failures++;
      $display("FAIL hs%0d_load_wait: LoadPC not seen within 10 cycles", n);
    end else if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      chk($sformatf("hs%0d_prog", n), {14'd0, prog_state}, {14'd0, exp[11:10]});
      chk($sformatf("hs%0d_pc", n), {6'd0, pc_init}, {6'd0, exp[9:0]});
    end
    start = 1'b0;
    tick();                                   // now in RUN
    repeat (run_cycles) tick();
    done = 1'b1;
    k = 0;
    tick();
    done = 1'b0;
    while (!ack && k < 20) begin
      tick();
      k++;
    end
    chk($sformatf("hs%0d_ack", n), {15'd0, ack}, 16'd1);
    chk($sformatf("hs%0d_cnt", n), cycle_count, 16'(run_cycles));
    tick();                                   // Start low: back to IDLE
    chk($sformatf("hs%0d_idle", n), {14'd0, dbg_state}, {14'd0, ST_IDLE});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; done = 1'b0; div_zero = 1'b0;

    //             rst st dn dz reps  state    prog  pc   ld en ak err    cnt
    vecs[0]  = mk(1, 0, 0, 0, 2,  ST_IDLE, 2'd0, 10'd0,   0, 0, 0, 2'b00, 16'd0);
    // program 1: Done after 10 RUN cycles, Start held through ACK
    vecs[1]  = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd1, 10'd0,   1, 0, 0, 2'b00, 16'd0);
    vecs[2]  = mk(0, 0, 0, 0, 1,  ST_RUN,  2'd1, 10'd0,   0, 1, 0, 2'b00, 16'd0);
    vecs[3]  = mk(0, 0, 0, 0, 10, ST_RUN,  2'd1, 10'd0,   0, 1, 0, 2'b00, 16'd10);
    vecs[4]  = mk(0, 0, 1, 0, 1,  ST_ACK,  2'd1, 10'd0,   0, 0, 1, 2'b00, 16'd10);
    vecs[5]  = mk(0, 1, 0, 0, 5,  ST_ACK,  2'd1, 10'd0,   0, 0, 1, 2'b00, 16'd10);
    vecs[6]  = mk(0, 0, 0, 0, 1,  ST_IDLE, 2'd0, 10'd0,   0, 0, 0, 2'b00, 16'd10);
    // program 2: DivZero pulse, Start pulses ignored in RUN
    vecs[7]  = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd2, 10'd96,  1, 0, 0, 2'b00, 16'd0);
    vecs[8]  = mk(0, 0, 0, 0, 1,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b00, 16'd0);
    vecs[9]  = mk(0, 0, 0, 0, 3,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b00, 16'd3);
    vecs[10] = mk(0, 1, 0, 1, 1,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b01, 16'd4);
    vecs[11] = mk(0, 1, 0, 0, 2,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b01, 16'd6);
    vecs[12] = mk(0, 0, 1, 0, 1,  ST_ACK,  2'd2, 10'd96,  0, 0, 1, 2'b01, 16'd6);
    vecs[13] = mk(0, 0, 0, 0, 1,  ST_IDLE, 2'd0, 10'd96,  0, 0, 0, 2'b01, 16'd6);
    // program 3: timeout after 16 RUN cycles; LOAD clears the old error
    vecs[14] = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd3, 10'd224, 1, 0, 0, 2'b00, 16'd0);
    vecs[15] = mk(0, 0, 0, 0, 1,  ST_RUN,  2'd3, 10'd224, 0, 1, 0, 2'b00, 16'd0);
    vecs[16] = mk(0, 0, 0, 0, 15, ST_RUN,  2'd3, 10'd224, 0, 1, 0, 2'b00, 16'd15);
    vecs[17] = mk(0, 0, 0, 0, 1,  ST_ACK,  2'd3, 10'd224, 0, 0, 1, 2'b10, 16'd15);
    vecs[18] = mk(0, 1, 1, 1, 2,  ST_ACK,  2'd3, 10'd224, 0, 0, 1, 2'b10, 16'd15);
    vecs[19] = mk(0, 0, 0, 0, 1,  ST_IDLE, 2'd0, 10'd224, 0, 0, 0, 2'b10, 16'd15);
    // index wrapped to 1: Done and DivZero on the 16th cycle
    vecs[20] = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd1, 10'd0,   1, 0, 0, 2'b00, 16'd0);
    vecs[21] = mk(0, 0, 0, 0, 1,  ST_RUN,  2'd1, 10'd0,   0, 1, 0, 2'b00, 16'd0);
    vecs[22] = mk(0, 0, 0, 0, 15, ST_RUN,  2'd1, 10'd0,   0, 1, 0, 2'b00, 16'd15);
    vecs[23] = mk(0, 0, 1, 1, 1,  ST_ACK,  2'd1, 10'd0,   0, 0, 1, 2'b01, 16'd15);
    vecs[24] = mk(0, 0, 0, 0, 1,  ST_IDLE, 2'd0, 10'd0,   0, 0, 0, 2'b01, 16'd15);
    // program 2 aborted by Reset mid-RUN; next Start runs program 1
    vecs[25] = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd2, 10'd96,  1, 0, 0, 2'b00, 16'd0);
    vecs[26] = mk(0, 0, 0, 0, 1,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b00, 16'd0);
    vecs[27] = mk(0, 0, 0, 0, 3,  ST_RUN,  2'd2, 10'd96,  0, 1, 0, 2'b00, 16'd3);
    vecs[28] = mk(1, 1, 1, 1, 1,  ST_IDLE, 2'd0, 10'd0,   0, 0, 0, 2'b00, 16'd0);
    vecs[29] = mk(0, 1, 0, 0, 1,  ST_LOAD, 2'd1, 10'd0,   1, 0, 0, 2'b00, 16'd0);
    vecs[30] = mk(1, 1, 0, 0, 1,  ST_IDLE, 2'd0, 10'd0,   0, 0, 0, 2'b00, 16'd0);

    #2;
    for (int i = 0; i < 31; i++) begin
      reset    = vecs[i].rst;
      start    = vecs[i].st;
      done     = vecs[i].dn;
      div_zero = vecs[i].dz;
      repeat (vecs[i].reps) tick();
      chk($sformatf("v%0d_state", i), {14'd0, dbg_state},  {14'd0, vecs[i].e_state});
      chk($sformatf("v%0d_prog", i),  {14'd0, prog_state}, {14'd0, vecs[i].e_prog});
      chk($sformatf("v%0d_pc", i),    {6'd0, pc_init},     {6'd0, vecs[i].e_pc});
      chk($sformatf("v%0d_load", i),  {15'd0, load_pc},    {15'd0, vecs[i].e_load});
      chk($sformatf("v%0d_en", i),    {15'd0, core_enable},{15'd0, vecs[i].e_en});
      chk($sformatf("v%0d_ack", i),   {15'd0, ack},        {15'd0, vecs[i].e_ack});
      chk($sformatf("v%0d_err", i),   {14'd0, err_code},   {14'd0, vecs[i].e_err});
      chk($sformatf("v%0d_cnt", i),   cycle_count,         vecs[i].e_cnt);
    end

    // Four back-to-back handshakes from reset: program order 1,2,3,1.
    reset = 1'b1; start = 1'b0; done = 1'b0; div_zero = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.push_back({2'd1, 10'd0});
    exp_q.push_back({2'd2, 10'd96});
    exp_q.push_back({2'd3, 10'd224});
    exp_q.push_back({2'd1, 10'd0});
    for (int n = 0; n < 4; n++) begin
      run_prog(2 + n, n);
    end
    chk("exp_q_drained", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
- REQ-001 SHALL have parameter PROG1_START, default 10'd0, start PC of program 1.
- REQ-002 SHALL have parameter PROG2_START, default 10'd96, start PC of program 2.
- REQ-003 SHALL have parameter PROG3_START, default 10'd224, start PC of program 3.
- REQ-004 SHALL have parameter TIMEOUT, default 16'd4000, maximum RUN cycles per program.
- REQ-005 SHALL have port CLK, input, 1 bit: the only clock; all state updates on its rising edge.
- REQ-006 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
- REQ-007 SHALL have port Start, input, 1 bit: request to run the next program (4-phase handshake with Ack).
- REQ-008 SHALL have port Done, input, 1 bit: core has executed its halt instruction.
- REQ-009 SHALL have port DivZero, input, 1 bit: divide-by-zero detected by the exception checker.
- REQ-010 SHALL have port ProgState, output, 2 bits: 00 idle, 01/10/11 = program 1/2/3 active.
- REQ-011 SHALL have port PCInit, output, 10 bits: start PC to be loaded into the core.
- REQ-012 SHALL have port LoadPC, output, 1 bit: one-cycle strobe that loads PCInit into the PC.
- REQ-013 SHALL have port CoreEnable, output, 1 bit: core may fetch and execute.
- REQ-014 SHALL have port Ack, output, 1 bit: program finished; results valid.
- REQ-015 SHALL have port ErrCode, output, 2 bits: bit0 = divide-by-zero seen, bit1 = timeout.
- REQ-016 SHALL have port CycleCount, output, 16 bits: RUN cycles for the current or last program.

Function
- REQ-017 SHALL implement the FSM states IDLE, LOAD, RUN and ACK.
- REQ-018 SHALL hold an internal next-program index in the range 1..3.
- REQ-019 In IDLE, ProgState SHALL be 00 and CoreEnable, LoadPC and Ack SHALL be 0.
- REQ-020 In IDLE with Start=1, the block SHALL move to LOAD on the next edge and set ProgState to the index.
- REQ-021 On the IDLE-to-LOAD edge, PCInit SHALL be set to the matching PROGn_START.
- REQ-022 In LOAD, LoadPC SHALL be 1 for exactly one cycle, CycleCount SHALL clear to 0 and ErrCode SHALL clear to 00.
- REQ-023 LOAD SHALL always go to RUN on the next edge.
- REQ-024 In RUN, CoreEnable SHALL be 1 and CycleCount SHALL increment by 1 each cycle, saturating at 16'hFFFF.
- REQ-025 In RUN with DivZero=1, ErrCode[0] SHALL set and stay set until the next LOAD; execution continues.
- REQ-026 In RUN with Done=1, the block SHALL go to ACK on the next edge; CycleCount does not increment on that edge.
- REQ-027 In RUN with Done=0 and CycleCount==TIMEOUT-1, the block SHALL set ErrCode[1] and go to ACK.
- REQ-028 If Done=1 and the timeout condition occur in the same cycle, Done SHALL win and ErrCode[1] SHALL stay 0.
- REQ-029 If DivZero=1 in the same cycle as Done=1 or timeout, ErrCode[0] SHALL still be set.
- REQ-030 In ACK, Ack SHALL be 1, CoreEnable SHALL be 0, and ProgState, PCInit, CycleCount and ErrCode SHALL hold.
- REQ-031 ACK SHALL be left only when Start=0; on that edge the state SHALL return to IDLE and the index SHALL advance 1→2→3→1.
- REQ-032 Start SHALL be ignored in LOAD and RUN; Done and DivZero SHALL be ignored outside RUN.
- REQ-033 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
- REQ-034 With Reset=1 at an edge, the block SHALL enter IDLE with index=1, ProgState=00, PCInit=PROG1_START, LoadPC=0, CoreEnable=0, Ack=0, ErrCode=00 and CycleCount=0.
- REQ-035 Reset SHALL take priority over all other inputs in every state, including mid-RUN, and SHALL abort the program without asserting Ack.

Verification
- REQ-036 Reset, then Start=1: LOAD next cycle with ProgState=01, PCInit=0, LoadPC=1 for 1 cycle; RUN follows; Done=1 after 10 RUN cycles → Ack=1, CycleCount=10, ErrCode=00.
- REQ-037 Three full handshakes: ProgState sequence 01, 10, 11, then 01 again; PCInit sequence 0, 96, 224, 0.
- REQ-038 DivZero pulsed 1 cycle mid-RUN, then Done: Ack with ErrCode=01; next program's LOAD clears it to 00.
- REQ-039 TIMEOUT=16, Done never asserted: Ack after 16 RUN cycles with ErrCode=10 and CycleCount=15; with Done=1 on the 16th cycle instead, ErrCode=00.
- REQ-040 Start held high through ACK for 5 cycles: Ack stays 1 and the state stays ACK; Start=0 → IDLE next edge; Start pulsed during RUN has no effect.
- REQ-041 Reset asserted during RUN of program 2: next cycle IDLE, ProgState=00, Ack=0, CoreEnable=0; the next Start runs program 1.
